// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory-controller port between two requesters: the processor
// core (a) and a second master such as a debugger or DMA engine (b).
// Requests are served one at a time with round-robin fairness on ties.
// A transaction the controller does not acknowledge within TIMEOUT wait
// cycles is aborted and reported to its requester with x_err=1.
//
// Ports
//   clk, sync_reset            clock, synchronous active-high reset
//   a_*/b_* req,we,addr,wdata  request side; fields held stable until x_done
//   a_*/b_* done,err,rdata     completion pulse, timeout flag, read data
//   mem_addr, mem_read_en,     controller command (one-cycle strobes)
//   mem_write_en, mem_write_data
//   mem_read_data, mem_read_ack, mem_write_ack   controller response
//   busy, grant_id             arbiter not idle; owner of the port (0=a,1=b)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  sync_reset,

   input  logic                  a_req,
   input  logic [DATA_W/8-1:0]   a_we,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic [DATA_W-1:0]     a_wdata,
   output logic                  a_done,
   output logic                  a_err,
   output logic [DATA_W-1:0]     a_rdata,

   input  logic                  b_req,
   input  logic [DATA_W/8-1:0]   b_we,
   input  logic [ADDR_W-1:0]     b_addr,
   input  logic [DATA_W-1:0]     b_wdata,
   output logic                  b_done,
   output logic                  b_err,
   output logic [DATA_W-1:0]     b_rdata,

   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_read_en,
   output logic [DATA_W/8-1:0]   mem_write_en,
   output logic [DATA_W-1:0]     mem_write_data,
   input  logic [DATA_W-1:0]     mem_read_data,
   input  logic                  mem_read_ack,
   input  logic                  mem_write_ack,

   output logic                  busy,
   output logic                  grant_id
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t              state_reg,      state_next;
   logic                grant_id_reg,   grant_id_next;
   logic                last_grant_reg, last_grant_next;
   logic [ADDR_W-1:0]   addr_reg,       addr_next;
   logic [BE_W-1:0]     we_reg,         we_next;
   logic [DATA_W-1:0]   wdata_reg,      wdata_next;
   logic [7:0]          cnt_reg,        cnt_next;
   logic                rd_en_reg,      rd_en_next;
   logic [BE_W-1:0]     wr_en_reg,      wr_en_next;

   logic                finish_ok;      // acknowledged completion this cycle
   logic                finish_to;      // timeout abort this cycle
   logic                pick_b;
   logic                ack;

   logic [1:0]          req_vec;
   logic [1:0]          done_vec;
   logic [1:0]          err_vec;
   logic [1:0]          eligible;
   logic [DATA_W-1:0]   rdata_arr [2];

   assign req_vec = {b_req, a_req};

   // ------------------------------------------------------------------
   // Per-requester completion registers. A requester whose done pulse is
   // high this cycle is masked from arbitration so its still-high request
   // is not granted a second time.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         localparam logic ID = (gi == 1);
         logic              done_reg;
         logic              err_reg;
         logic [DATA_W-1:0] rdata_reg;
         logic              mine;

         assign mine          = (finish_ok | finish_to) & (grant_id_reg == ID);
         assign eligible[gi]  = req_vec[gi] & ~done_reg;
         assign done_vec[gi]  = done_reg;
         assign err_vec[gi]   = err_reg;
         assign rdata_arr[gi] = rdata_reg;

         always_ff @(posedge clk) begin
            if (sync_reset) begin
               done_reg  <= 1'b0;
               err_reg   <= 1'b0;
               rdata_reg <= '0;
            end else begin
               done_reg <= mine;
               if (mine) begin
                  err_reg <= finish_to;
                  if (finish_to)
                     rdata_reg <= '0;
                  else if (we_reg == '0)
                     rdata_reg <= mem_read_data;
               end
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_reg      <= IDLE;
         grant_id_reg   <= 1'b0;
         last_grant_reg <= 1'b1;   // b counts as served last, so a wins the first tie
         addr_reg       <= '0;
         we_reg         <= '0;
         wdata_reg      <= '0;
         cnt_reg        <= '0;
         rd_en_reg      <= 1'b0;
         wr_en_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         grant_id_reg   <= grant_id_next;
         last_grant_reg <= last_grant_next;
         addr_reg       <= addr_next;
         we_reg         <= we_next;
         wdata_reg      <= wdata_next;
         cnt_reg        <= cnt_next;
         rd_en_reg      <= rd_en_next;
         wr_en_reg      <= wr_en_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. Strobes are computed on the grant edge so that they
   // are registered and visible exactly during the ISSUE cycle.
   // ------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      grant_id_next   = grant_id_reg;
      last_grant_next = last_grant_reg;
      addr_next       = addr_reg;
      we_next         = we_reg;
      wdata_next      = wdata_reg;
      cnt_next        = cnt_reg;
      rd_en_next      = 1'b0;
      wr_en_next      = '0;
      finish_ok       = 1'b0;
      finish_to       = 1'b0;
      pick_b          = 1'b0;
      ack             = 1'b0;

      case (state_reg)
         IDLE: begin
            if (eligible != 2'b00) begin
               // b wins if it is alone, or on a tie when a was served last
               pick_b        = eligible[1] & (~eligible[0] | ~last_grant_reg);
               grant_id_next = pick_b;
               addr_next     = pick_b ? b_addr  : a_addr;
               we_next       = pick_b ? b_we    : a_we;
               wdata_next    = pick_b ? b_wdata : a_wdata;
               rd_en_next    = (we_next == '0);
               wr_en_next    = we_next;
               state_next    = ISSUE;
            end
         end

         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT;
         end

         WAIT: begin
            // Only the ack matching the pending access type completes it
            ack = (we_reg == '0) ? mem_read_ack : mem_write_ack;
            if (ack) begin
               finish_ok       = 1'b1;
               last_grant_next = grant_id_reg;
               state_next      = IDLE;
            end else if (cnt_reg + 8'd1 == 8'(TIMEOUT)) begin
               finish_to       = 1'b1;
               last_grant_next = grant_id_reg;
               state_next      = IDLE;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign busy           = (state_reg != IDLE);
   assign grant_id       = grant_id_reg;
   assign mem_addr       = addr_reg;
   assign mem_write_data = wdata_reg;
   assign mem_read_en    = rd_en_reg;
   assign mem_write_en   = wr_en_reg;

   assign a_done  = done_vec[0];
   assign a_err   = err_vec[0];
   assign a_rdata = rdata_arr[0];
   assign b_done  = done_vec[1];
   assign b_err   = err_vec[1];
   assign b_rdata = rdata_arr[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (TIMEOUT=8). A table of single
// transactions is applied in a loop; contention, stale/wrong acks, timeout
// and reset in the middle of a wait are written out as explicit sequences.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int TO     = 8;
   localparam logic [31:0] FILLER = 32'h1357_9BDF;

   logic              clk = 1'b0;
   logic              sync_reset;
   logic              a_req, b_req;
   logic [BE_W-1:0]   a_we, b_we;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [DATA_W-1:0] a_wdata, b_wdata;
   logic              a_done, a_err, b_done, b_err;
   logic [DATA_W-1:0] a_rdata, b_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read_en;
   logic [BE_W-1:0]   mem_write_en;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;
   logic              mem_read_ack, mem_write_ack;
   logic              busy, grant_id;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
      .clk(clk), .sync_reset(sync_reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack),
      .busy(busy), .grant_id(grant_id)
   );

   int checks_total  = 0;
   int checks_passed = 0;

   // Pulse counters sampled on the falling edge
   int rd_pulses = 0;
   int wr_pulses = 0;
   int done_a    = 0;
   int done_b    = 0;

   always @(negedge clk) begin
      if (mem_read_en)          rd_pulses <= rd_pulses + 1;
      if (mem_write_en != '0)   wr_pulses <= wr_pulses + 1;
      if (a_done)               done_a    <= done_a + 1;
      if (b_done)               done_b    <= done_b + 1;
   end

   typedef struct {
      bit          id;
      logic [3:0]  we;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          delay;      // cycles from strobe cycle to ack cycle (>=1)
      logic [31:0] mem_data;   // read data driven in the ack cycle
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic get_done(input bit id);
      return id ? b_done : a_done;
   endfunction

   function automatic logic get_err(input bit id);
      return id ? b_err : a_err;
   endfunction

   function automatic logic [31:0] get_rdata(input bit id);
      return id ? b_rdata : a_rdata;
   endfunction

   function automatic int get_done_cnt(input bit id);
      return id ? done_b : done_a;
   endfunction

   task automatic drive_req(input bit id, input logic [3:0] we,
                            input logic [15:0] addr, input logic [31:0] wdata);
      if (id) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
      end
   endtask

   task automatic drop_req(input bit id);
      if (id) b_req = 1'b0;
      else    a_req = 1'b0;
   endtask

   task automatic do_reset();
      sync_reset = 1'b1;
      a_req = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
      mem_read_ack = 1'b0; mem_write_ack = 1'b0; mem_read_data = FILLER;
      repeat (2) @(posedge clk);
      #1 sync_reset = 1'b0;
   endtask

   // Wait (bounded) for a strobe; n = index of the falling edge it was seen on
   task automatic wait_strobe(output int n, output bit found);
      int i;
      found = 1'b0;
      n = -1;
      i = 0;
      while (!found && i < 12) begin
         @(negedge clk);
         if (mem_read_en || mem_write_en != '0) begin
            found = 1'b1;
            n = i;
         end
         i++;
      end
   endtask

   // One pulse of the ack matching the access type, starting now
   task automatic pulse_ack(input bit is_write, input logic [31:0] data);
      if (is_write) mem_write_ack = 1'b1;
      else          mem_read_ack  = 1'b1;
      mem_read_data = data;
      @(posedge clk);
      #1;
      mem_read_ack  = 1'b0;
      mem_write_ack = 1'b0;
      mem_read_data = FILLER;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int rd0, wr0, d0, o0, n;
      bit found;
      rd0 = rd_pulses; wr0 = wr_pulses;
      d0 = get_done_cnt(v.id); o0 = get_done_cnt(!v.id);
      drive_req(v.id, v.we, v.addr, v.wdata);
      wait_strobe(n, found);
      check("vec_strobe_seen", 32'(found), 32'd1);
      check("vec_strobe_latency", 32'(n), 32'd1);
      check("vec_mem_addr", 32'(mem_addr), 32'(v.addr));
      check("vec_grant_id", 32'(grant_id), 32'(v.id));
      check("vec_busy", 32'(busy), 32'd1);
      if (v.we == '0) begin
         check("vec_read_en", 32'(mem_read_en), 32'd1);
      end else begin
         check("vec_write_en", 32'(mem_write_en), 32'(v.we));
         check("vec_write_data", mem_write_data, v.wdata);
      end
      repeat (v.delay) @(posedge clk);
      #1;
      pulse_ack(v.we != '0, v.mem_data);
      @(negedge clk);
      check("vec_done", 32'(get_done(v.id)), 32'd1);
      check("vec_err", 32'(get_err(v.id)), 32'(v.exp_err));
      check("vec_rdata", get_rdata(v.id), v.exp_rdata);
      @(posedge clk);
      #1 drop_req(v.id);
      @(negedge clk);   // a wrong regrant in the done cycle would strobe here
      @(posedge clk);
      #1;
      check("vec_read_pulses", 32'(rd_pulses - rd0), (v.we == '0) ? 32'd1 : 32'd0);
      check("vec_write_pulses", 32'(wr_pulses - wr0), (v.we == '0) ? 32'd0 : 32'd1);
      check("vec_done_count", 32'(get_done_cnt(v.id) - d0), 32'd1);
      check("vec_other_done", 32'(get_done_cnt(!v.id) - o0), 32'd0);
      $display("txn vec%0d: req=%s we=%h addr=%h delay=%0d -> rdata=%h err=%0d",
               idx, v.id ? "b" : "a", v.we, v.addr, v.delay, get_rdata(v.id), get_err(v.id));
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n, rd0, wr0, d0, o0;
      bit found;
      int served [2];
      bit exp_id;

      // Contention leaves a_rdata=C0DE0004, b_rdata=C0DE0005.
      vecs[0] = '{1'b0, 4'h0, 16'h0010, 32'h0000_0000, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b1, 4'h4, 16'h0020, 32'h00AB_0000, 1, 32'hFFFF_FFFF, 32'hC0DE_0005, 1'b0};
      vecs[2] = '{1'b0, 4'hF, 16'h1234, 32'h1234_5678, 1, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b1, 4'h0, 16'hFFFF, 32'h0000_0000, 7, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
      vecs[4] = '{1'b0, 4'h0, 16'h0ABC, 32'h0000_0000, 8, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0};
      vecs[5] = '{1'b1, 4'h8, 16'h0000, 32'hAB00_0000, 3, 32'h2222_2222, 32'hCAFE_F00D, 1'b0};

      // ---------------- reset state ----------------
      do_reset();
      @(negedge clk);
      check("rst_ctrl", 32'({busy, grant_id, mem_read_en, mem_write_en}), 32'd0);
      check("rst_done_err", 32'({a_done, a_err, b_done, b_err}), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_write_data, 32'd0);
      check("rst_rdata", a_rdata | b_rdata, 32'd0);

      // ---------------- contention: a,b each 3 reads ----------------
      @(posedge clk);
      #1;
      served[0] = 0; served[1] = 0;
      drive_req(1'b0, 4'h0, 16'h0100, 32'h0);
      drive_req(1'b1, 4'h0, 16'h0200, 32'h0);
      for (int t = 0; t < 6; t++) begin
         exp_id = 1'(t % 2);
         wait_strobe(n, found);
         check("cont_strobe_seen", 32'(found), 32'd1);
         check("cont_order", 32'(grant_id), 32'(exp_id));
         check("cont_addr", 32'(mem_addr),
               (exp_id ? 32'h0200 : 32'h0100) + 32'(served[exp_id]));
         @(posedge clk);
         #1;
         pulse_ack(1'b0, 32'hC0DE_0000 + 32'(t));
         @(negedge clk);
         check("cont_done", 32'(get_done(exp_id)), 32'd1);
         check("cont_other_done", 32'(get_done(!exp_id)), 32'd0);
         check("cont_rdata", get_rdata(exp_id), 32'hC0DE_0000 + 32'(t));
         $display("txn cont%0d: req=%s addr=%h rdata=%h", t, exp_id ? "b" : "a",
                  mem_addr, get_rdata(exp_id));
         @(posedge clk);
         #1;
         served[exp_id]++;
         if (served[exp_id] == 3) drop_req(exp_id);
         else drive_req(exp_id, 4'h0, (exp_id ? 16'h0200 : 16'h0100) + 16'(served[exp_id]), 32'h0);
      end
      @(negedge clk);
      check("cont_no_regrant", 32'({busy, mem_read_en}), 32'd0);

      // ---------------- table-driven single transactions ----------------
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // ---------------- wrong / stale ack on a pending write ----------------
      d0 = done_b; wr0 = wr_pulses; rd0 = rd_pulses;
      drive_req(1'b1, 4'h3, 16'h0300, 32'h0000_BEEF);
      wait_strobe(n, found);
      check("stale_strobe", 32'(mem_write_en), 32'h3);
      mem_write_ack = 1'b1;            // arrives during ISSUE: stale
      @(posedge clk);
      #1;
      mem_write_ack = 1'b0;
      mem_read_ack  = 1'b1;            // wrong kind for a write, held 3 cycles
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stale_no_done", 32'(b_done), 32'd0);
         @(posedge clk);
         #1;
      end
      mem_read_ack = 1'b0;
      @(negedge clk);
      check("stale_no_done_late", 32'(b_done), 32'd0);
      @(posedge clk);
      #1;
      pulse_ack(1'b1, 32'hFFFF_0000);
      @(negedge clk);
      check("stale_done", 32'(b_done), 32'd1);
      check("stale_err", 32'(b_err), 32'd0);
      check("stale_rdata_kept", b_rdata, 32'hCAFE_F00D);
      $display("txn stale: req=b we=3 addr=0300 err=%0d", b_err);
      @(posedge clk);
      #1 drop_req(1'b1);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("stale_done_count", 32'(done_b - d0), 32'd1);
      check("stale_pulses", 32'({16'(wr_pulses - wr0), 16'(rd_pulses - rd0)}), 32'h0001_0000);

      // ---------------- timeout then late ack ----------------
      d0 = done_a; o0 = done_b; rd0 = rd_pulses;
      drive_req(1'b0, 4'h0, 16'h0077, 32'h0);
      found = 1'b0; n = 0;
      while (!found && n < 20) begin
         @(negedge clk);
         if (a_done) found = 1'b1;
         else n++;
      end
      check("to_done_seen", 32'(found), 32'd1);
      check("to_latency", 32'(n), 32'(TO + 2));
      check("to_err", 32'(a_err), 32'd1);
      check("to_rdata_zero", a_rdata, 32'd0);
      $display("txn timeout: req=a addr=0077 cycles=%0d err=%0d", n, a_err);
      @(posedge clk);
      #1 drop_req(1'b0);
      @(posedge clk);
      #1;
      pulse_ack(1'b0, 32'h7777_7777);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      check("late_ack_done_count", 32'(done_a - d0), 32'd1);
      check("late_ack_other", 32'(done_b - o0), 32'd0);
      check("late_ack_rdata", a_rdata, 32'd0);
      check("late_ack_idle", 32'(busy), 32'd0);
      check("to_read_pulses", 32'(rd_pulses - rd0), 32'd1);

      // ---------------- reset in the middle of WAIT ----------------
      drive_req(1'b0, 4'h0, 16'h0055, 32'h0);
      wait_strobe(n, found);
      check("rw_strobe_seen", 32'(found), 32'd1);
      @(posedge clk);
      #1;
      sync_reset = 1'b1;
      drop_req(1'b0);
      @(posedge clk);
      #1 sync_reset = 1'b0;
      d0 = done_a; o0 = done_b;
      @(negedge clk);
      check("rw_busy", 32'(busy), 32'd0);
      check("rw_strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
      check("rw_dones", 32'({a_done, b_done}), 32'd0);
      check("rw_b_rdata", b_rdata, 32'd0);
      check("rw_mem_addr", 32'(mem_addr), 32'd0);
      @(posedge clk);
      #1;
      pulse_ack(1'b0, 32'h5555_5555);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      check("rw_late_ack_done", 32'((done_a - d0) + (done_b - o0)), 32'd0);
      check("rw_late_ack_idle", 32'(busy), 32'd0);
      $display("txn reset_wait: req=a addr=0055 aborted");

      // Tie after reset: a must win, then b is served
      drive_req(1'b0, 4'h0, 16'h00A0, 32'h0);
      drive_req(1'b1, 4'h0, 16'h00B0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         exp_id = 1'(k);
         wait_strobe(n, found);
         check("tie_grant", 32'(grant_id), 32'(exp_id));
         check("tie_addr", 32'(mem_addr), exp_id ? 32'h00B0 : 32'h00A0);
         @(posedge clk);
         #1;
         pulse_ack(1'b0, 32'h600D_F000 + 32'(k));
         @(negedge clk);
         check("tie_done", 32'(get_done(exp_id)), 32'd1);
         check("tie_rdata", get_rdata(exp_id), 32'h600D_F000 + 32'(k));
         $display("txn tie%0d: req=%s rdata=%h", k, exp_id ? "b" : "a", get_rdata(exp_id));
         @(posedge clk);
         #1 drop_req(exp_id);
      end
      repeat (2) @(negedge clk);
      check("end_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
